detector_jogada: RTL

DETECTOR_JOGADA -- requirements
Module: detector_jogada

---
 rtl/detector_jogada.sv | 118 +++++++++++
 1 files changed

// File: rtl/detector_jogada.sv
// Debounced player-button detector: synchronizes the raw buttons, waits for a
// stable nonzero pattern, reports it once, then waits for a stable release.
module detector_jogada #(
  parameter int DEBOUNCE_CICLOS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] botoes,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       multiplo,
  output logic [1:0] db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CICLOS);

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    CONTA         = 2'd1,
    REGISTRA      = 2'd2,
    ESPERA_SOLTAR = 2'd3
  } estado_t;

  estado_t       estado;
  estado_t       estado_prox;
  logic [3:0]    s_meta;
  logic [3:0]    s;
  logic [3:0]    candidato;
  logic [3:0]    candidato_prox;
  logic [CW-1:0] contador;
  logic [CW-1:0] contador_prox;
  logic [CW-1:0] contador_inc;
  logic          um_quente;

  // Two-flop synchronizer: nothing downstream ever sees the raw buttons.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_meta <= 4'd0;
      s      <= 4'd0;
    end else begin
      s_meta <= botoes;
      s      <= s_meta;
    end
  end

  // State, candidate pattern, debounce counter and the reported play.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= OCIOSO;
      candidato <= 4'd0;
      contador  <= '0;
      jogada    <= 4'd0;
    end else begin
      estado    <= estado_prox;
      candidato <= candidato_prox;
      contador  <= contador_prox;
      if (estado == REGISTRA) begin
        jogada <= candidato;
      end
    end
  end

  assign contador_inc = contador + CW'(1);

  // Next-state logic: accept a stable press, report it once, then require
  // a stable release before another press can be considered.
  always_comb begin
    estado_prox    = estado;
    candidato_prox = candidato;
    contador_prox  = contador;
    case (estado)
      OCIOSO: begin
        if (habilita && (s != 4'd0)) begin
          candidato_prox = s;
          contador_prox  = CW'(1);
          estado_prox    = (LIMITE == CW'(1)) ? REGISTRA : CONTA;
        end
      end
      CONTA: begin
        if (!habilita || (s != candidato)) begin
          estado_prox   = OCIOSO;
          contador_prox = '0;
        end else begin
          contador_prox = contador_inc;
          if (contador_inc == LIMITE) begin
            estado_prox = REGISTRA;
          end
        end
      end
      REGISTRA: begin
        estado_prox   = ESPERA_SOLTAR;
        contador_prox = '0;
      end
      ESPERA_SOLTAR: begin
        if (s != 4'd0) begin
          contador_prox = '0;
        end else if (contador_inc == LIMITE) begin
          estado_prox   = OCIOSO;
          contador_prox = '0;
        end else begin
          contador_prox = contador_inc;
        end
      end
      default: begin
        estado_prox   = OCIOSO;
        contador_prox = '0;
      end
    endcase
  end

  assign um_quente    = (candidato != 4'd0) && ((candidato & (candidato - 4'd1)) == 4'd0);
  assign jogada_feita = (estado == REGISTRA) && um_quente;
  assign multiplo     = (estado == REGISTRA) && !um_quente;
  assign db_estado    = estado;

endmodule
